// File: rtl/ipml_mc_fifo_v1_0.sv
// Multi-channel single-clock FIFO: c_CH_NUM logical queues share one simple-dual-port RAM.
// Define IPML_MC_FIFO_ERR_FLAG_EN to add sticky per-channel wr_overflow / rd_underflow ports.
module ipml_mc_fifo_v1_0 #(
    parameter int c_CH_NUM           = 4,
    parameter int c_CH_SEL_WIDTH     = 2,
    parameter int c_CH_DEPTH_WIDTH   = 9,
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_OUTPUT_REG       = 0,
    parameter int c_ALMOST_FULL_NUM  = 508,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       wr_en,
    input  logic [c_CH_SEL_WIDTH-1:0]                  wr_ch,
    input  logic [c_DATA_WIDTH-1:0]                    wr_data,
    input  logic                                       rd_en,
    input  logic [c_CH_SEL_WIDTH-1:0]                  rd_ch,
    output logic [c_DATA_WIDTH-1:0]                    rd_data,
    output logic                                       rd_valid,
    output logic [c_CH_SEL_WIDTH-1:0]                  rd_data_ch,
    input  logic [c_CH_NUM-1:0]                        ch_flush,
    output logic [c_CH_NUM-1:0]                        full,
    output logic [c_CH_NUM-1:0]                        empty,
    output logic [c_CH_NUM-1:0]                        almost_full,
    output logic [c_CH_NUM-1:0]                        almost_empty,
`ifdef IPML_MC_FIFO_ERR_FLAG_EN
    output logic [c_CH_NUM*(c_CH_DEPTH_WIDTH+1)-1:0]   water_level,
    output logic [c_CH_NUM-1:0]                        wr_overflow,
    output logic [c_CH_NUM-1:0]                        rd_underflow
`else
    output logic [c_CH_NUM*(c_CH_DEPTH_WIDTH+1)-1:0]   water_level
`endif
);

    localparam int W  = c_CH_DEPTH_WIDTH;
    localparam int PW = W + 1;
    localparam int AW = c_CH_SEL_WIDTH + W;

    localparam logic [PW-1:0] DEPTH = PW'(2 ** W);
    localparam logic [PW-1:0] AF_TH = PW'(c_ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_TH = PW'(c_ALMOST_EMPTY_NUM);

    logic [PW-1:0]           wptr [c_CH_NUM];
    logic [PW-1:0]           rptr [c_CH_NUM];
    logic [PW-1:0]           level [c_CH_NUM];
    logic [c_CH_NUM-1:0]     wr_hit, rd_hit, wr_acc, rd_acc;
    logic [PW-1:0]           wr_ptr_sel, rd_ptr_sel;
    logic [AW-1:0]           wr_addr, rd_addr;

    logic [c_DATA_WIDTH-1:0] mem [2**AW];

    logic                      s1_valid;
    logic [c_DATA_WIDTH-1:0]   s1_data;
    logic [c_CH_SEL_WIDTH-1:0] s1_ch;

    // Flags come from pre-edge pointers, so a full/empty channel never flows through.
    always_comb begin
        wr_hit       = '0;
        rd_hit       = '0;
        wr_acc       = '0;
        rd_acc       = '0;
        wr_ptr_sel   = '0;
        rd_ptr_sel   = '0;
        full         = '0;
        empty        = '0;
        almost_full  = '0;
        almost_empty = '0;
        water_level  = '0;
        for (int i = 0; i < c_CH_NUM; i++) begin
            level[i]        = wptr[i] - rptr[i];
            empty[i]        = (level[i] == '0);
            full[i]         = (level[i] == DEPTH);
            almost_full[i]  = (level[i] >= AF_TH);
            almost_empty[i] = (level[i] <= AE_TH);
            water_level[i*PW +: PW] = level[i];
            wr_hit[i] = wr_en && (wr_ch == c_CH_SEL_WIDTH'(i));
            rd_hit[i] = rd_en && (rd_ch == c_CH_SEL_WIDTH'(i));
            wr_acc[i] = wr_hit[i] && !full[i]  && !ch_flush[i];
            rd_acc[i] = rd_hit[i] && !empty[i] && !ch_flush[i];
            if (wr_hit[i]) wr_ptr_sel = wptr[i];
            if (rd_hit[i]) rd_ptr_sel = rptr[i];
        end
    end

    assign wr_addr = {wr_ch, wr_ptr_sel[W-1:0]};
    assign rd_addr = {rd_ch, rd_ptr_sel[W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_CH_NUM; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_CH_NUM; i++) begin
                if (ch_flush[i]) begin
                    wptr[i] <= '0;
                    rptr[i] <= '0;
                end else begin
                    if (wr_acc[i]) wptr[i] <= wptr[i] + PW'(1);
                    if (rd_acc[i]) rptr[i] <= rptr[i] + PW'(1);
                end
            end
        end
    end

    // NOTE: the RAM array has no reset so it can map onto block RAM; only its control state is reset.
    always_ff @(posedge clk) begin
        if (|wr_acc) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_ch    <= '0;
        end else begin
            s1_valid <= |rd_acc;
            if (|rd_acc) begin
                s1_data <= mem[rd_addr];
                s1_ch   <= rd_ch;
            end
        end
    end

    generate
        if (c_OUTPUT_REG != 0) begin : g_out_reg
            logic                      s2_valid;
            logic [c_DATA_WIDTH-1:0]   s2_data;
            logic [c_CH_SEL_WIDTH-1:0] s2_ch;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                    s2_ch    <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                        s2_ch   <= s1_ch;
                    end
                end
            end

            assign rd_valid   = s2_valid;
            assign rd_data    = s2_data;
            assign rd_data_ch = s2_ch;
        end else begin : g_no_out_reg
            assign rd_valid   = s1_valid;
            assign rd_data    = s1_data;
            assign rd_data_ch = s1_ch;
        end
    endgenerate

`ifdef IPML_MC_FIFO_ERR_FLAG_EN
    logic wr_oor, rd_oor;

    // Accesses to a channel index beyond c_CH_NUM are charged to channel 0.
    assign wr_oor = wr_en && !(|wr_hit);
    assign rd_oor = rd_en && !(|rd_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_overflow  <= '0;
            rd_underflow <= '0;
        end else begin
            for (int i = 0; i < c_CH_NUM; i++) begin
                if (ch_flush[i]) begin
                    wr_overflow[i]  <= 1'b0;
                    rd_underflow[i] <= 1'b0;
                end else begin
                    if ((wr_hit[i] && !wr_acc[i]) || (i == 0 && wr_oor)) wr_overflow[i]  <= 1'b1;
                    if ((rd_hit[i] && !rd_acc[i]) || (i == 0 && rd_oor)) rd_underflow[i] <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/ipml_mc_fifo_v1_0.md
# ipml_mc_fifo_v1_0

Single-clock, multi-channel synchronous FIFO: `c_CH_NUM` independent logical FIFOs share one inferred simple-dual-port RAM, each owning a region of 2^`c_CH_DEPTH_WIDTH` words. It is the single-clock, multi-queue successor to the per-instance sync/async FIFO wrappers. It sits between packet demultiplexers and per-channel consumers (DMA, UART, I/O test engines). It adds per-channel flags and water levels, per-channel flush, and a selectable output register.

## Interface
Parameters:
- `c_CH_NUM`, 4: number of channels, 1..16.
- `c_CH_SEL_WIDTH`, 2: channel-select width; must equal max(1, clog2(`c_CH_NUM`)).
- `c_CH_DEPTH_WIDTH`, 9: per-channel depth width, 4..12. Depth D = 2^`c_CH_DEPTH_WIDTH`.
- `c_DATA_WIDTH`, 32: data width, 1..256.
- `c_OUTPUT_REG`, 0: 1 adds an output register stage.
- `c_ALMOST_FULL_NUM`, 508: almost-full threshold, 1..D.
- `c_ALMOST_EMPTY_NUM`, 4: almost-empty threshold, 0..D-1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write request.
- `wr_ch` in `c_CH_SEL_WIDTH`: write channel.
- `wr_data` in `c_DATA_WIDTH`: write data.
- `rd_en` in 1: read request.
- `rd_ch` in `c_CH_SEL_WIDTH`: read channel.
- `rd_data` out `c_DATA_WIDTH`: read data.
- `rd_valid` out 1: `rd_data` carries a newly read word.
- `rd_data_ch` out `c_CH_SEL_WIDTH`: channel of the word on `rd_data`.
- `ch_flush` in `c_CH_NUM`: per-channel synchronous clear.
- `full`, `empty`, `almost_full`, `almost_empty` out `c_CH_NUM`: per-channel flags; bit i belongs to channel i.
- `water_level` out `c_CH_NUM*(c_CH_DEPTH_WIDTH+1)`: per-channel word count; channel i occupies slice [i*(W+1) +: W+1], where W = `c_CH_DEPTH_WIDTH`.

## Operation
- Each channel has a write pointer and a read pointer, each W+1 bits wide. RAM address = {ch, ptr[W-1:0]}. Pointers wrap naturally modulo 2^(W+1).
- Per-channel level = wptr - rptr, computed modulo 2^(W+1).
  - `empty` = (level == 0). `full` = (level == D).
  - `almost_full` = (level >= `c_ALMOST_FULL_NUM`). `almost_empty` = (level <= `c_ALMOST_EMPTY_NUM`).
- Write acceptance: accepted iff `wr_en`, `wr_ch` < `c_CH_NUM`, !`full[wr_ch]` and !`ch_flush[wr_ch]`. A rejected write is dropped silently; state is unchanged.
- Read acceptance: accepted iff `rd_en`, `rd_ch` < `c_CH_NUM`, !`empty[rd_ch]` and !`ch_flush[rd_ch]`.
- Flags are evaluated on pre-edge state:
  - A full channel rejects a write even if a read on the same channel is accepted in that cycle.
  - An empty channel rejects a read even if a write on the same channel is accepted in that cycle.
  - There is no flow-through.
- Simultaneous accepted write and read on the same non-full, non-empty channel leaves its level unchanged. Different channels update independently.
- `ch_flush[i]` sets both pointers of channel i to 0 at the edge. Flush has priority over any same-cycle access to that channel. RAM contents are not cleared.
- Reset values:
  - All pointers 0.
  - `empty` = all 1s; `almost_empty` = all 1s; `full` = 0; `almost_full` = 0.
  - `water_level` = 0.
  - `rd_valid` = 0, `rd_data` = 0, `rd_data_ch` = 0.
  - RAM is not initialised.
- `rst` asserted mid-operation discards all queued data; reads in flight produce no `rd_valid`.

## Timing
- Flags and `water_level` are decoded from registered pointers. They reflect an accepted operation in the cycle after its edge.
- Read latency with `c_OUTPUT_REG`=0: `rd_valid`, `rd_data` and `rd_data_ch` update 1 cycle after the accepting edge.
- Read latency with `c_OUTPUT_REG`=1: these outputs update 2 cycles after the accepting edge.
- `rd_valid` pulses for exactly 1 cycle per accepted read. Back-to-back reads, on any channels, sustain 1 word per cycle.
- `rd_data` and `rd_data_ch` hold their last value when `rd_valid`=0.
- RAM read-during-write to the same address cannot occur, because empty/full gating forbids it.

## Configuration
- `IPML_MC_FIFO_ERR_FLAG_EN` defined: adds output ports `wr_overflow` and `rd_underflow`, each `c_CH_NUM` wide.
  - Bit i is sticky; it sets when a write (respectively read) addressed to channel i is rejected.
  - An out-of-range `wr_ch`/`rd_ch` sets bit 0.
  - Bit i clears on `rst` or on `ch_flush[i]`.
- Macro undefined: these ports and all related logic are absent. Rejected accesses leave no trace.

## Test plan
- Reset, then idle -> `empty`=4'hF, `almost_empty`=4'hF, `full`=0, all `water_level` slices 0, `rd_valid`=0.
- Write 512 words 0..511 to ch 2 (W=9), then write 1 more -> `full[2]`=1 after the 512th write; the 513th is dropped; `almost_full[2]`=1 from level 508.
- Read ch 2 ×512 with `c_OUTPUT_REG`=0 -> data 0..511 in order, `rd_valid` 1 cycle after each accepting edge, `rd_data_ch`=2, `empty[2]`=1 at the end.
- Interleave writes to ch 0 and reads from ch 1 with both at level 3, plus a same-cycle write and read on ch 0 -> levels 4/2 after the first cycle, then ch 0 holds 4; data order preserved per channel.
- Level 5 on ch 3, assert `ch_flush[3]` together with `wr_en` to ch 3 -> level 0, write discarded, other channels untouched.
- With the macro defined: read empty ch 1 -> `rd_underflow[1]`=1 and stays set until `ch_flush[1]`; repeat the 512-word fill with `c_OUTPUT_REG`=1 and confirm 2-cycle read latency.
